add_result_display: RTL and testbench

- Downstream display stage for the 4-bit ripple adder lab.
- Captures the adder operands and outputs (A, B, S, Cout) on a load strobe.
- Drives a 4-digit multiplexed, common-anode 7-segment display, all outputs active-low: digit3 = A, digit2 = B, digit1 = Cout, digit0 = S, all shown in hex.
- A set carry makes digit1 blink so overflow is visible on the board.

---
 rtl/add_result_display.sv | 172 +++++++++++++++++
 tb/tb_add_result_display.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/add_result_display.sv
`default_nettype none
// ============================================================================
// Module   : add_result_display
// Brief    : Captures 4-bit adder operands/results and scans them onto a
//            4-digit common-anode 7-segment display; overflow makes digit1 blink.
// Revision : 1.0 - initial release
// ============================================================================
module add_result_display #(
    parameter int SCAN_DIV    = 50000,
    parameter int BLINK_TICKS = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] S,
    input  logic       Cout,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       shown
);

    localparam int c_scan_w  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_blink_w = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [c_scan_w-1:0]  c_scan_last  = c_scan_w'(SCAN_DIV - 1);
    localparam logic [c_scan_w-1:0]  c_scan_one   = c_scan_w'(1);
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_TICKS - 1);
    localparam logic [c_blink_w-1:0] c_blink_one  = c_blink_w'(1);

    logic [3:0]           r_a;
    logic [3:0]           r_b;
    logic [3:0]           r_s;
    logic                 r_cout;
    logic                 r_shown;
    logic [c_scan_w-1:0]  r_scan;
    logic [1:0]           r_idx;
    logic [c_blink_w-1:0] r_blink;
    logic                 r_phase_on;
    logic [6:0]           r_seg;
    logic                 r_dp;
    logic [3:0]           r_an;

    logic                 w_tick;
    logic [3:0]           w_nib;
    logic [6:0]           w_font;
    logic [6:0]           w_seg_next;
    logic                 w_dp_next;
    logic [3:0]           w_an_next;

    assign w_tick = r_shown && (r_scan == c_scan_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= 4'd0;
            r_b     <= 4'd0;
            r_s     <= 4'd0;
            r_cout  <= 1'b0;
            r_shown <= 1'b0;
        end else if (load) begin
            r_a     <= A;
            r_b     <= B;
            r_s     <= S;
            r_cout  <= Cout;
            r_shown <= 1'b1;
        end
    end

    // Scan position only advances once something has been captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan <= '0;
            r_idx  <= 2'd0;
        end else if (r_shown) begin
            if (w_tick) begin
                r_scan <= '0;
                r_idx  <= r_idx + 2'd1;
            end else begin
                r_scan <= r_scan + c_scan_one;
            end
        end
    end

    // A fresh capture always restarts the blink with the digit visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink    <= '0;
            r_phase_on <= 1'b1;
        end else if (load) begin
            r_blink    <= '0;
            r_phase_on <= 1'b1;
        end else if (w_tick) begin
            if (r_blink == c_blink_last) begin
                r_blink    <= '0;
                r_phase_on <= ~r_phase_on;
            end else begin
                r_blink <= r_blink + c_blink_one;
            end
        end
    end

    always_comb begin
        w_nib = r_s;
        case (r_idx)
            2'd0:    w_nib = r_s;
            2'd1:    w_nib = {3'b000, r_cout};
            2'd2:    w_nib = r_b;
            default: w_nib = r_a;
        endcase
    end

    always_comb begin
        w_font = 7'b1111111;
        case (w_nib)
            4'h0: w_font = 7'b1000000;
            4'h1: w_font = 7'b1111001;
            4'h2: w_font = 7'b0100100;
            4'h3: w_font = 7'b0110000;
            4'h4: w_font = 7'b0011001;
            4'h5: w_font = 7'b0010010;
            4'h6: w_font = 7'b0000010;
            4'h7: w_font = 7'b1111000;
            4'h8: w_font = 7'b0000000;
            4'h9: w_font = 7'b0010000;
            4'hA: w_font = 7'b0001000;
            4'hB: w_font = 7'b0000011;
            4'hC: w_font = 7'b1000110;
            4'hD: w_font = 7'b0100001;
            4'hE: w_font = 7'b0000110;
            default: w_font = 7'b0001110;
        endcase
    end

    always_comb begin
        w_an_next  = 4'b1111;
        w_seg_next = 7'b1111111;
        w_dp_next  = 1'b1;
        if (r_shown) begin
            w_an_next  = ~(4'b0001 << r_idx);
            w_seg_next = w_font;
            if ((r_idx == 2'd1) && r_cout) begin
                // Overflow digit: segments and dp go dark together, anode stays on.
                if (r_phase_on) begin
                    w_dp_next = 1'b0;
                end else begin
                    w_seg_next = 7'b1111111;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= 4'b1111;
            r_seg <= 7'b1111111;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
            r_dp  <= w_dp_next;
        end
    end

    assign an    = r_an;
    assign seg   = r_seg;
    assign dp    = r_dp;
    assign shown = r_shown;

endmodule
`default_nettype wire

// File: tb/tb_add_result_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_result_display
// Brief    : Randomised and directed bench for add_result_display against an
//            arithmetic reference model (SCAN_DIV=4, BLINK_TICKS=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_add_result_display;

    localparam int SD = 4;
    localparam int BT = 2;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] S;
    logic       Cout;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       shown;

    add_result_display #(.SCAN_DIV(SD), .BLINK_TICKS(BT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .A     (A),
        .B     (B),
        .S     (S),
        .Cout  (Cout),
        .seg   (seg),
        .dp    (dp),
        .an    (an),
        .shown (shown)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [6:0] font [16];

    // Model: shown flag, edges elapsed while shown, ticks since last capture.
    bit         m_shown;
    int         m_ncyc;
    int         m_nticks;
    logic [3:0] m_a, m_b, m_s;
    logic       m_c;

    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       exp_shown;

    function automatic int m_idx();
        return (m_ncyc / SD) % 4;
    endfunction

    function automatic bit m_tick();
        return m_shown && ((m_ncyc % SD) == SD - 1);
    endfunction

    function automatic bit m_phase_on();
        return ((m_nticks / BT) % 2) == 0;
    endfunction

    task automatic model_reset();
        m_shown  = 0;
        m_ncyc   = 0;
        m_nticks = 0;
        m_a = 4'd0; m_b = 4'd0; m_s = 4'd0; m_c = 1'b0;
        exp_an = 4'b1111; exp_seg = 7'b1111111; exp_dp = 1'b1; exp_shown = 1'b0;
    endtask

    task automatic model_edge(input logic ld);
        int         idx;
        bit         tick;
        logic [3:0] nib;
        idx  = m_idx();
        tick = m_tick();
        exp_an = 4'b1111; exp_seg = 7'b1111111; exp_dp = 1'b1;
        if (m_shown) begin
            exp_an = 4'b1111;
            exp_an[idx] = 1'b0;
            case (idx)
                0: nib = m_s;
                1: nib = {3'b000, m_c};
                2: nib = m_b;
                default: nib = m_a;
            endcase
            exp_seg = font[nib];
            if (idx == 1 && m_c) begin
                if (m_phase_on()) exp_dp = 1'b0;
                else exp_seg = 7'b1111111;
            end
        end
        if (m_shown) m_ncyc++;
        if (ld) begin
            m_a = A; m_b = B; m_s = S; m_c = Cout;
            m_shown  = 1;
            m_nticks = 0;
        end else if (tick) begin
            m_nticks++;
        end
        exp_shown = m_shown;
    endtask

    task automatic check(input string tag);
        vectors++;
        assert ({an, seg, dp, shown} === {exp_an, exp_seg, exp_dp, exp_shown})
        else begin
            miscompares++;
            $error("FAIL %s: observed an=%b seg=%b dp=%b shown=%b, expected an=%b seg=%b dp=%b shown=%b",
                   tag, an, seg, dp, shown, exp_an, exp_seg, exp_dp, exp_shown);
        end
    endtask

    task automatic step(input logic ld, input string tag);
        load = ld;
        @(posedge clk);
        if (rst_n) model_edge(ld);
        #1;
        check(tag);
    endtask

    task automatic set_in(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] s, input logic c);
        A = a; B = b; S = s; Cout = c;
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        check(tag);
        for (int i = 0; i < 2; i++) step(1'b0, tag);
        rst_n = 1'b1;
    endtask

    initial begin
        bit found;
        font[0]  = 7'b1000000; font[1]  = 7'b1111001; font[2]  = 7'b0100100; font[3]  = 7'b0110000;
        font[4]  = 7'b0011001; font[5]  = 7'b0010010; font[6]  = 7'b0000010; font[7]  = 7'b1111000;
        font[8]  = 7'b0000000; font[9]  = 7'b0010000; font[10] = 7'b0001000; font[11] = 7'b0000011;
        font[12] = 7'b1000110; font[13] = 7'b0100001; font[14] = 7'b0000110; font[15] = 7'b0001110;

        load = 1'b0;
        set_in(4'd0, 4'd0, 4'd0, 1'b0);
        rst_n = 1'b1;
        model_reset();
        #1;
        async_reset("reset_async");

        // Blank after release with no load
        for (int i = 0; i < 20; i++) step(1'b0, "blank_idle");

        // Basic capture 3 + 5 = 8
        set_in(4'd3, 4'd5, 4'd8, 1'b0);
        step(1'b1, "basic_load");
        step(1'b0, "basic_first");
        vectors++;
        assert ({an, seg, dp} === {4'b1110, 7'b0000000, 1'b1})
        else begin
            miscompares++;
            $error("FAIL basic_literal: observed an=%b seg=%b dp=%b, expected an=1110 seg=0000000 dp=1",
                   an, seg, dp);
        end
        for (int i = 0; i < 20; i++) step(1'b0, "basic_scan");

        // Overflow blink F + 1 = 0 carry 1
        set_in(4'hF, 4'h1, 4'h0, 1'b1);
        step(1'b1, "ovf_load");
        for (int i = 0; i < 48; i++) step(1'b0, "ovf_blink");

        // Load arriving on a tick during the OFF phase
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_tick() && !m_phase_on()) begin
                step(1'b1, "load_on_tick");
                found = 1;
            end else begin
                step(1'b0, "seek_off_tick");
            end
        end
        vectors++;
        assert (found)
        else begin
            miscompares++;
            $error("FAIL load_tick_seek: observed found=%0d, expected found=1", found);
        end
        for (int i = 0; i < 24; i++) step(1'b0, "after_load_tick");

        // Recapture mid-digit at index 0
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_idx() == 0 && (m_ncyc % SD) == 1) begin
                S = 4'hA;
                step(1'b1, "recap_load");
                step(1'b0, "recap_next");
                found = 1;
            end else begin
                step(1'b0, "recap_seek");
            end
        end
        vectors++;
        assert (found && seg === 7'b0001000 && an === 4'b1110)
        else begin
            miscompares++;
            $error("FAIL recap_literal: observed found=%0d an=%b seg=%b, expected found=1 an=1110 seg=0001000",
                   found, an, seg);
        end
        for (int i = 0; i < 12; i++) step(1'b0, "recap_scan");

        // Async reset at index 2
        for (int i = 0; i < 40 && m_idx() != 2; i++) step(1'b0, "seek_idx2");
        async_reset("reset_mid_scan");
        for (int i = 0; i < 6; i++) step(1'b0, "post_reset_idle");
        set_in(4'h7, 4'h9, 4'h0, 1'b1);
        step(1'b1, "post_reset_load");
        for (int i = 0; i < 8; i++) step(1'b0, "post_reset_scan");

        // Randomised traffic with inputs changing every cycle
        for (int i = 0; i < 500; i++) begin
            set_in(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
            if (i == 250) async_reset("rand_reset");
            step(($urandom_range(0, 15) == 0), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
